// File: rtl/bool_lut_eval_if.sv
// bool_lut_eval_if: bundles the load, evaluate and sweep signals of bool_lut_eval.
//   load_valid/load_tt/load_ready : truth-table load handshake (accepted on
//                                    a rising edge with load_valid && load_ready)
//   in_valid/in_vec               : single-vector evaluation request
//   f_valid/f_out                 : registered evaluation result
//   sweep_start/sweep_busy/...    : autonomous truth-table sweep and minterm count
// Modports: slave = the function unit, master = whoever drives it.
interface bool_lut_eval_if #(
    parameter int N_IN = 3
);
    localparam int TT_W = 2 ** N_IN;

    logic            load_valid;
    logic [TT_W-1:0] load_tt;
    logic            load_ready;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            f_valid;
    logic            f_out;
    logic            sweep_start;
    logic            sweep_busy;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_f;
    logic            sweep_done;
    logic [N_IN:0]   minterm_count;

    modport slave (
        input  load_valid, load_tt, in_valid, in_vec, sweep_start,
        output load_ready, f_valid, f_out, sweep_busy, sweep_valid,
               sweep_idx, sweep_f, sweep_done, minterm_count
    );

    modport master (
        output load_valid, load_tt, in_valid, in_vec, sweep_start,
        input  load_ready, f_valid, f_out, sweep_busy, sweep_valid,
               sweep_idx, sweep_f, sweep_done, minterm_count
    );
endinterface

// File: rtl/bool_lut_eval.sv
// bool_lut_eval: N_IN-input Boolean function held as a loadable truth table.
// Bit k of the table is F for input index k (index MSB = first input).
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : bool_lut_eval_if slave (load / evaluate / sweep signals)
//   dbg_state  : current FSM state (0 IDLE, 1 SWEEP, 2 DONE)
// Handshake: a load is taken on a rising edge where load_valid && load_ready;
// load_ready is high only in IDLE. in_valid needs no ready: every request is
// answered by a one-cycle f_valid pulse on the following cycle.
module bool_lut_eval #(
    parameter int          N_IN     = 3,
    parameter logic [63:0] RESET_TT = 64'hE3
) (
    input  logic            clk,
    input  logic            rst_n,
    bool_lut_eval_if.slave  bus,
    output logic [1:0]      dbg_state
);
    localparam int TT_W = 2 ** N_IN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TT_W-1:0] tt;
    logic [N_IN:0]   acc;
    logic [N_IN-1:0] idx_inc;
    logic            last_row;
    logic            start_sweep;
    logic            step_sweep;

    // The sweep row counter is sweep_idx itself; it stops at the last row.
    assign idx_inc     = bus.sweep_idx + N_IN'(1);
    assign last_row    = (bus.sweep_idx == N_IN'(TT_W - 1));
    assign start_sweep = (state == IDLE) && (state_next == SWEEP);
    assign step_sweep  = (state == SWEEP) && (state_next == SWEEP);

    assign bus.load_ready = (state == IDLE);
    assign dbg_state      = state;

    // Load wins over sweep_start when both arrive in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sweep_start && !bus.load_valid) state_next = SWEEP;
            SWEEP:   if (last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            tt                <= RESET_TT[TT_W-1:0];
            acc               <= '0;
            bus.f_valid       <= 1'b0;
            bus.f_out         <= 1'b0;
            bus.sweep_busy    <= 1'b0;
            bus.sweep_valid   <= 1'b0;
            bus.sweep_idx     <= '0;
            bus.sweep_f       <= 1'b0;
            bus.sweep_done    <= 1'b0;
            bus.minterm_count <= '0;
        end else begin
            state <= state_next;

            if (bus.load_valid && (state == IDLE)) begin
                tt <= bus.load_tt;
            end

            // Evaluation reads the table before any same-edge load lands.
            bus.f_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.f_out <= tt[bus.in_vec];
            end

            // Sweep outputs are registered from the next state so row 0 is
            // already visible in the first cycle of SWEEP.
            bus.sweep_busy  <= (state_next == SWEEP);
            bus.sweep_valid <= (state_next == SWEEP);
            bus.sweep_done  <= (state_next == DONE);

            if (start_sweep) begin
                bus.sweep_idx <= '0;
                bus.sweep_f   <= tt[0];
                acc           <= (N_IN + 1)'(tt[0]);
            end else if (step_sweep) begin
                bus.sweep_idx <= idx_inc;
                bus.sweep_f   <= tt[idx_inc];
                acc           <= acc + (N_IN + 1)'(tt[idx_inc]);
            end

            // acc already includes the last row shown, so publish it as is.
            if ((state == SWEEP) && (state_next == DONE)) begin
                bus.minterm_count <= acc;
            end
        end
    end
endmodule

// File: tb/tb_bool_lut_eval.sv
module tb_bool_lut_eval;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] st3;
    logic [1:0] st4;
    int         checks = 0;
    int         errors = 0;

    // Reference tables as the bench believes them to be.
    logic [7:0]  tt3;
    logic [15:0] tt4;

    bool_lut_eval_if #(.N_IN(3)) b3 ();
    bool_lut_eval_if #(.N_IN(4)) b4 ();

    bool_lut_eval #(.N_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .dbg_state(st3));
    bool_lut_eval #(.N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .dbg_state(st4));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic ref_f(input logic [63:0] t, input int idx);
        return ((t >> idx) & 64'd1) != 64'd0;
    endfunction

    function automatic int ref_count(input logic [63:0] t, input int rows);
        int n = 0;
        for (int k = 0; k < rows; k++) n += ((t >> k) & 64'd1) != 0 ? 1 : 0;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (drive and sample on negedge) ----------------
    task automatic load3(input logic [7:0] v);
        @(negedge clk);
        b3.load_valid = 1'b1;
        b3.load_tt    = v;
        @(negedge clk);
        b3.load_valid = 1'b0;
        tt3 = v;
    endtask

    task automatic eval3(input logic [2:0] v, input string name);
        @(negedge clk);
        b3.in_valid = 1'b1;
        b3.in_vec   = v;
        @(negedge clk);
        b3.in_valid = 1'b0;
        chk({name, "_fv"}, b3.f_valid, 1'b1);
        chk({name, "_f"}, b3.f_out, ref_f(tt3, v));
        @(negedge clk);
        chk({name, "_fv_low"}, b3.f_valid, 1'b0);
    endtask

    // Full sweep of the 3-input unit; optionally pokes a load mid-sweep.
    task automatic sweep3(input bit poke_load);
        @(negedge clk);
        b3.sweep_start = 1'b1;
        @(negedge clk);
        b3.sweep_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("sw3_valid", b3.sweep_valid, 1'b1);
            chk("sw3_idx", b3.sweep_idx, i);
            chk("sw3_f", b3.sweep_f, ref_f(tt3, i));
            chk("sw3_busy", b3.sweep_busy, 1'b1);
            chk("sw3_ready", b3.load_ready, 1'b0);
            if (poke_load && i == 3) begin
                b3.load_valid = 1'b1;
                b3.load_tt    = ~tt3;
                b3.sweep_start = 1'b1;
            end
            @(negedge clk);
            b3.load_valid  = 1'b0;
            b3.sweep_start = 1'b0;
        end
        chk("sw3_done", b3.sweep_done, 1'b1);
        chk("sw3_valid_end", b3.sweep_valid, 1'b0);
        chk("sw3_count", b3.minterm_count, ref_count(tt3, 8));
        chk("sw3_ready_done", b3.load_ready, 1'b0);
        @(negedge clk);
        chk("sw3_ready_after", b3.load_ready, 1'b1);
        chk("sw3_done_pulse", b3.sweep_done, 1'b0);
        chk("sw3_count_hold", b3.minterm_count, ref_count(tt3, 8));
    endtask

    task automatic sweep4();
        @(negedge clk);
        b4.sweep_start = 1'b1;
        @(negedge clk);
        b4.sweep_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("sw4_valid", b4.sweep_valid, 1'b1);
            chk("sw4_idx", b4.sweep_idx, i);
            chk("sw4_f", b4.sweep_f, ref_f(tt4, i));
            @(negedge clk);
        end
        chk("sw4_done", b4.sweep_done, 1'b1);
        chk("sw4_count", b4.minterm_count, ref_count(tt4, 16));
        @(negedge clk);
        chk("sw4_ready", b4.load_ready, 1'b1);
    endtask

    typedef struct {
        logic [2:0] in_vec;
        logic       exp_f;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] sweep_tts[4];

    initial begin
        vecs[0] = '{3'd0, 1'b1}; vecs[1] = '{3'd1, 1'b1};
        vecs[2] = '{3'd2, 1'b0}; vecs[3] = '{3'd3, 1'b0};
        vecs[4] = '{3'd4, 1'b0}; vecs[5] = '{3'd5, 1'b1};
        vecs[6] = '{3'd6, 1'b1}; vecs[7] = '{3'd7, 1'b1};
        sweep_tts[0] = 8'h80; sweep_tts[1] = 8'h00;
        sweep_tts[2] = 8'hFF; sweep_tts[3] = 8'h69;

        b3.load_valid = 0; b3.load_tt = '0; b3.in_valid = 0; b3.in_vec = '0; b3.sweep_start = 0;
        b4.load_valid = 0; b4.load_tt = '0; b4.in_valid = 0; b4.in_vec = '0; b4.sweep_start = 0;
        tt3 = 8'hE3;
        tt4 = 16'h00E3;

        // Reset values
        #12;
        chk("rst_f_out", b3.f_out, 1'b0);
        chk("rst_f_valid", b3.f_valid, 1'b0);
        chk("rst_sweep_valid", b3.sweep_valid, 1'b0);
        chk("rst_sweep_idx", b3.sweep_idx, 0);
        chk("rst_sweep_busy", b3.sweep_busy, 1'b0);
        chk("rst_sweep_done", b3.sweep_done, 1'b0);
        chk("rst_count", b3.minterm_count, 0);
        chk("rst_load_ready", b3.load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default table, back-to-back evaluation
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b3.in_valid = 1'b1;
            b3.in_vec   = vecs[i].in_vec;
            @(negedge clk);
            chk("tab_fv", b3.f_valid, 1'b1);
            chk("tab_f", b3.f_out, vecs[i].exp_f);
        end
        b3.in_valid = 1'b0;
        @(negedge clk);
        chk("tab_fv_low", b3.f_valid, 1'b0);
        chk("tab_f_hold", b3.f_out, vecs[7].exp_f);

        // Sweep of reset table, then specific tables
        sweep3(1'b0);
        for (int i = 0; i < 4; i++) begin
            load3(sweep_tts[i]);
            sweep3(1'b0);
        end

        // Same-cycle load + evaluate uses the old table
        load3(8'hE3);
        @(negedge clk);
        b3.load_valid = 1'b1; b3.load_tt = 8'h96;
        b3.in_valid = 1'b1;   b3.in_vec = 3'd0;
        @(negedge clk);
        b3.load_valid = 1'b0;
        chk("ld_eval_old", b3.f_out, 1'b1);
        b3.in_vec = 3'd0;
        @(negedge clk);
        b3.in_valid = 1'b0;
        chk("ld_eval_new", b3.f_out, 1'b0);
        tt3 = 8'h96;

        // Load and sweep_start together: load wins, no sweep
        @(negedge clk);
        b3.load_valid = 1'b1; b3.load_tt = 8'h5A; b3.sweep_start = 1'b1;
        @(negedge clk);
        b3.load_valid = 1'b0; b3.sweep_start = 1'b0;
        tt3 = 8'h5A;
        chk("cont_no_busy", b3.sweep_busy, 1'b0);
        chk("cont_no_valid", b3.sweep_valid, 1'b0);
        chk("cont_ready", b3.load_ready, 1'b1);
        eval3(3'd1, "cont_eval");

        // Load during sweep is ignored
        sweep3(1'b1);
        eval3(3'd6, "sweep_ld_ign");

        // Randomised loads / evaluations / sweeps
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: load3(8'($urandom_range(0, 255)));
                1: eval3(3'($urandom_range(0, 7)), "rnd_eval");
                default: begin
                    logic [7:0] nv = 8'($urandom_range(0, 255));
                    logic [2:0] iv = 3'($urandom_range(0, 7));
                    @(negedge clk);
                    b3.load_valid = 1'b1; b3.load_tt = nv;
                    b3.in_valid = 1'b1;   b3.in_vec = iv;
                    @(negedge clk);
                    b3.load_valid = 1'b0; b3.in_valid = 1'b0;
                    chk("rnd_old_tt", b3.f_out, ref_f(tt3, iv));
                    tt3 = nv;
                end
            endcase
            if (n % 10 == 9) sweep3(1'(n % 20 == 19));
        end

        // 4-input unit: reset table and random tables
        sweep4();
        for (int n = 0; n < 3; n++) begin
            logic [15:0] nv = 16'($urandom_range(0, 65535));
            @(negedge clk);
            b4.load_valid = 1'b1; b4.load_tt = nv;
            @(negedge clk);
            b4.load_valid = 1'b0;
            tt4 = nv;
            sweep4();
        end
        @(negedge clk);
        b4.load_valid = 1'b1; b4.load_tt = 16'hFFFF;
        @(negedge clk);
        b4.load_valid = 1'b0;
        tt4 = 16'hFFFF;
        sweep4();

        // Reset in the middle of a sweep
        load3(8'h00);
        @(negedge clk);
        b3.sweep_start = 1'b1;
        @(negedge clk);
        b3.sweep_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_idx", b3.sweep_idx, i);
            @(negedge clk);
        end
        chk("mid_row4", b3.sweep_idx, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", b3.sweep_valid, 1'b0);
        chk("mid_rst_idx", b3.sweep_idx, 0);
        chk("mid_rst_busy", b3.sweep_busy, 1'b0);
        chk("mid_rst_count", b3.minterm_count, 0);
        chk("mid_rst_f", b3.f_out, 1'b0);
        chk("mid_rst_ready", b3.load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tt3 = 8'hE3;
        tt4 = 16'h00E3;
        eval3(3'd0, "post_rst_eval");
        sweep3(1'b0);
        sweep4();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
